sdram_traffic_gen: RTL

Parametrised write/read-back traffic generator and checker for the sdram_phy user interface. It writes NUM_BURSTS bursts of BURST_LEN words with a selectable data pattern at stepped addresses, then reads each burst back and compares every word. It reports error count, first failing address, timeout and pass/fail. It sits between board-level control (start/status) and sdram_phy, for bring-up and regression of the SDRAM path.

---
 rtl/sdram_traffic_gen.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_traffic_gen.sv
// Write/read-back traffic generator and checker for the sdram_phy user port; optional SDRAM_TG_ERR_INJECT_EN adds err_inject.
// Latency: one word per accepted ack; status registered one cycle after the DONE state.
// Backpressure: waits on sdram_busy/init_done and per-word acks; aborts after TIMEOUT_CYC idle cycles.
module sdram_traffic_gen #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 21,
    parameter int BURST_LEN   = 256,
    parameter int NUM_BURSTS  = 4,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_STEP   = 256,
    parameter int PATTERN     = 0,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk_100m,
    input  logic              rst_n,
    input  logic              start,
    input  logic              loop_en,
`ifdef SDRAM_TG_ERR_INJECT_EN
    input  logic              err_inject,
`endif
    input  logic              sdram_init_done,
    input  logic              sdram_busy,
    output logic              sdram_wr_req,
    input  logic              sdram_wr_ack,
    output logic [ADDR_W-1:0] sys_wraddr,
    output logic [8:0]        sdwr_byte,
    output logic [DATA_W-1:0] sys_data_in,
    output logic              sdram_rd_req,
    input  logic              sdram_rd_ack,
    output logic [ADDR_W-1:0] sys_rdaddr,
    output logic [8:0]        sdrd_byte,
    input  logic [DATA_W-1:0] sys_data_out,
    output logic              tg_busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [15:0]       pass_cnt
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_WAIT    = 4'd1;
    localparam logic [3:0] S_WR_REQ  = 4'd2;
    localparam logic [3:0] S_WR_DATA = 4'd3;
    localparam logic [3:0] S_RD_IDLE = 4'd4;
    localparam logic [3:0] S_RD_REQ  = 4'd5;
    localparam logic [3:0] S_RD_DATA = 4'd6;
    localparam logic [3:0] S_NEXT    = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [8:0]  K_LAST  = 9'(BURST_LEN - 1);
    localparam logic [10:0] B_LAST  = 11'(NUM_BURSTS - 1);
    localparam int MASK_W = ((DATA_W + 31) / 32) * 32;
    localparam logic [MASK_W-1:0] A5_FULL = {((DATA_W + 31) / 32){32'hA5A5_A5A5}};
    localparam logic [DATA_W-1:0] A5_MASK = A5_FULL[DATA_W-1:0];

    logic [3:0]        state_q, state_d;
    logic [10:0]       burst_q, burst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] gbase_q, gbase_d;
    logic [8:0]        k_q, k_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] ferr_q, ferr_d;
    logic              ferr_seen_q, ferr_seen_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              tmo_flag_q, tmo_flag_d;
    logic [15:0]       pass_cnt_q, pass_cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic [ADDR_W-1:0] word_addr;
    logic [DATA_W-1:0] exp_word;
    logic              inj_bit;
    logic              counting;
    logic              ack;

    // Global index g = burst*BURST_LEN + k is tracked as a running base plus k.
    function automatic logic [DATA_W-1:0] pat_word(input logic [DATA_W-1:0] g,
                                                   input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] inc;
        inc = g + DATA_W'(1);
        case (PATTERN)
            1:       return ~inc;
            2:       return DATA_W'(a) ^ A5_MASK;
            default: return inc;
        endcase
    endfunction

    assign word_addr = addr_q + ADDR_W'(k_q);
    assign exp_word  = pat_word(gbase_q + DATA_W'(k_q), word_addr);

`ifdef SDRAM_TG_ERR_INJECT_EN
    logic inject_q;
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            inject_q <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            inject_q <= err_inject;
        end
    end
    assign inj_bit = inject_q && (burst_q == 11'd0) && (k_q == 9'd0) && (state_q == S_WR_REQ);
`else
    assign inj_bit = 1'b0;
`endif

    assign counting = (state_q == S_WAIT) || (state_q == S_WR_REQ) || (state_q == S_WR_DATA) ||
                      (state_q == S_RD_IDLE) || (state_q == S_RD_DATA);
    // Only the ack of the active phase counts as progress.
    assign ack = (((state_q == S_WR_REQ) || (state_q == S_WR_DATA)) && sdram_wr_ack) ||
                 ((state_q == S_RD_DATA) && sdram_rd_ack);

    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        addr_d      = addr_q;
        gbase_d     = gbase_q;
        k_d         = k_q;
        err_cnt_d   = err_cnt_q;
        ferr_d      = ferr_q;
        ferr_seen_d = ferr_seen_q;
        done_d      = done_q;
        pass_d      = pass_q;
        tmo_flag_d  = tmo_flag_q;
        pass_cnt_d  = pass_cnt_q;
        tmo_d       = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    burst_d     = 11'd0;
                    addr_d      = ADDR_W'(BASE_ADDR);
                    gbase_d     = '0;
                    k_d         = 9'd0;
                    err_cnt_d   = 16'd0;
                    ferr_d      = '0;
                    ferr_seen_d = 1'b0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    tmo_flag_d  = 1'b0;
                    pass_cnt_d  = 16'd0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sdram_init_done && !sdram_busy) state_d = S_WR_REQ;
            end
            S_WR_REQ, S_WR_DATA: begin
                if (sdram_wr_ack) begin
                    if (k_q == K_LAST) begin
                        k_d     = 9'd0;
                        state_d = S_RD_IDLE;
                    end else begin
                        k_d     = k_q + 9'd1;
                        state_d = S_WR_DATA;
                    end
                end
            end
            S_RD_IDLE: begin
                if (!sdram_busy) state_d = S_RD_REQ;
            end
            S_RD_REQ: state_d = S_RD_DATA;
            S_RD_DATA: begin
                if (sdram_rd_ack) begin
                    if (sys_data_out != exp_word) begin
                        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                        if (!ferr_seen_q) begin
                            ferr_d      = word_addr;
                            ferr_seen_d = 1'b1;
                        end
                    end
                    if (k_q == K_LAST) begin
                        k_d     = 9'd0;
                        state_d = S_NEXT;
                    end else begin
                        k_d = k_q + 9'd1;
                    end
                end
            end
            S_NEXT: begin
                if (burst_q == B_LAST) begin
                    pass_cnt_d = pass_cnt_q + 16'd1;
                    if (loop_en) begin
                        burst_d = 11'd0;
                        addr_d  = ADDR_W'(BASE_ADDR);
                        gbase_d = '0;
                        state_d = S_WR_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    burst_d = burst_q + 11'd1;
                    addr_d  = addr_q + ADDR_W'(ADDR_STEP);
                    gbase_d = gbase_q + DATA_W'(BURST_LEN);
                    state_d = S_WR_REQ;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                pass_d  = (err_cnt_q == 16'd0) && !tmo_flag_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q || ack || !counting) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            tmo_d      = '0;
            tmo_flag_d = 1'b1;
            state_d    = S_DONE;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            burst_q     <= 11'd0;
            addr_q      <= '0;
            gbase_q     <= '0;
            k_q         <= 9'd0;
            err_cnt_q   <= 16'd0;
            ferr_q      <= '0;
            ferr_seen_q <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            tmo_flag_q  <= 1'b0;
            pass_cnt_q  <= 16'd0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            addr_q      <= addr_d;
            gbase_q     <= gbase_d;
            k_q         <= k_d;
            err_cnt_q   <= err_cnt_d;
            ferr_q      <= ferr_d;
            ferr_seen_q <= ferr_seen_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            tmo_flag_q  <= tmo_flag_d;
            pass_cnt_q  <= pass_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    assign sdram_wr_req   = (state_q == S_WR_REQ);
    assign sdram_rd_req   = (state_q == S_RD_REQ);
    assign sys_wraddr     = addr_q;
    assign sys_rdaddr     = addr_q;
    assign sdwr_byte      = 9'(BURST_LEN);
    assign sdrd_byte      = 9'(BURST_LEN);
    assign sys_data_in    = exp_word ^ {{(DATA_W-1){1'b0}}, inj_bit};
    assign tg_busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = tmo_flag_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = ferr_q;
    assign pass_cnt       = pass_cnt_q;

endmodule
